bpsk_modem: RTL and testbench

//  Single-clock BPSK modem: modulates a serial bit stream onto a 1-cycle-per-symbol sine carrier for a DAC,
//  and coherently demodulates ADC samples (integrate-and-dump correlator) back to bits. Sits between the

---
 rtl/bpsk_modem.sv | 136 +++++++++++++
 tb/tb_bpsk_modem.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bpsk_modem.sv
// BPSK modem: one carrier cycle per symbol. The transmit side writes a sine carrier, with its phase
// set by the current bit, to the DAC. The receive side correlates ADC samples against the same sine
// table, sums one symbol (integrate-and-dump) and slices the sum to a bit.
module bpsk_modem #(
  parameter int unsigned ADC_BITS = 12,
  parameter int unsigned SYM_LEN  = 16,
  parameter int unsigned RX_DELAY = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADC_BITS-1:0] adc_in,
  input  logic                bit_data_in,
  input  logic                bit_data_in_en,
  output logic                bit_data_out,
  output logic [ADC_BITS-1:0] dac_out
);

  localparam int unsigned PW     = $clog2(SYM_LEN);
  localparam int unsigned PROD_W = 2 * ADC_BITS + 1;
  localparam int unsigned ACC_W  = PROD_W + PW;
  localparam int          AMP    = (2 ** (ADC_BITS - 1)) - 1;

  localparam logic [ADC_BITS-1:0] MID    = {1'b1, {(ADC_BITS - 1){1'b0}}};
  localparam logic [PW-1:0]       P_LAST = PW'(SYM_LEN - 1);
  localparam logic [PW-1:0]       RX_OFF = PW'(RX_DELAY % SYM_LEN);

  // pi in Q30 fixed point, for the constant sine-table generator
  localparam longint PI_Q30 = 64'sd3373259426;

  // round(AMP * sin(2*pi*k/SYM_LEN)). Fold to the first quadrant, then evaluate a Taylor series
  // to x^15 in Q30. The truncation error stays far below half an output LSB.
  function automatic logic signed [ADC_BITS-1:0] lut_val(input int unsigned k);
    longint      x;
    longint      x2;
    longint      term;
    longint      sum;
    longint      v;
    int unsigned kk;
    logic        neg;
    kk  = k % SYM_LEN;
    neg = (kk >= SYM_LEN / 2);
    if (neg) kk = kk - SYM_LEN / 2;
    if (kk > SYM_LEN / 4) kk = SYM_LEN / 2 - kk;
    x    = (PI_Q30 * 64'sd2 * longint'(kk)) / longint'(SYM_LEN);
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int n = 1; n <= 7; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    v = (sum * longint'(AMP) + (longint'(1) <<< 29)) >>> 30;
    if (neg) v = -v;
    return ADC_BITS'(v);
  endfunction

  // Sine table shared by the modulator and the correlator
  logic signed [ADC_BITS-1:0] lut [SYM_LEN];

  for (genvar g = 0; g < int'(SYM_LEN); g++) begin : g_lut
    assign lut[g] = lut_val(g);
  end

  logic [PW-1:0]              p;
  logic                       tx_bit;
  logic [ADC_BITS-1:0]        adc_q;
  logic signed [ACC_W-1:0]    acc;

  logic signed [ADC_BITS-1:0] lut_tx;
  logic signed [ADC_BITS-1:0] tx_val;
  logic [ADC_BITS-1:0]        dac_d;

  logic [PW-1:0]              rx_idx;
  logic signed [ADC_BITS-1:0] lut_rx;
  logic signed [ADC_BITS:0]   x;
  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]    acc_sum;

  // Phase counter, plus the tx bit latch that loads only at the symbol boundary (p wraps to 0)
  always_ff @(posedge clk) begin
    if (rst) begin
      p      <= '0;
      tx_bit <= 1'b0;
    end else begin
      p <= p + PW'(1);
      if (p == P_LAST && bit_data_in_en) begin
        tx_bit <= bit_data_in;
      end
    end
  end

  // Modulator: bit 1 sends the table as is, bit 0 sends it inverted. The symmetric table keeps
  // MID +/- LUT inside [1, 2*MID-1].
  always_comb begin
    lut_tx = lut[p];
    tx_val = tx_bit ? lut_tx : -lut_tx;
    dac_d  = MID + $unsigned(tx_val);
  end

  // Registered DAC output, one clock behind the phase counter
  always_ff @(posedge clk) begin
    if (rst) begin
      dac_out <= MID;
    end else begin
      dac_out <= dac_d;
    end
  end

  // Correlator: the local replica phase lags p by the tx->adc_q pipeline depth, so in loopback
  // rx_idx 0 meets tx sample 0
  always_comb begin
    rx_idx  = p - RX_OFF;
    lut_rx  = lut[rx_idx];
    x       = $signed({1'b0, adc_q}) - $signed({1'b0, MID});
    prod    = PROD_W'(x) * PROD_W'(lut_rx);
    acc_sum = acc + ACC_W'(prod);
  end

  // Input register, plus integrate-and-dump. A zero sum slices to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      adc_q        <= MID;
      acc          <= '0;
      bit_data_out <= 1'b0;
    end else begin
      adc_q <= adc_in;
      if (rx_idx != P_LAST) begin
        acc <= acc_sum;
      end else begin
        bit_data_out <= (acc_sum > $signed(ACC_W'(0)));
        acc          <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bpsk_modem.sv
// Directed bench for bpsk_modem. It runs in loopback (adc_in = dac_out) or with a forced ADC value.
// Expected values come from a hand-entered sine table and the documented latency.
module tb_bpsk_modem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] adc_in;
  logic [11:0] adc_force;
  logic        loopback;
  logic        bit_data_in;
  logic        bit_data_in_en;
  logic        bit_data_out;
  logic [11:0] dac_out;

  int checks = 0;
  int errors = 0;
  int n      = 0;  // edges since the last reset edge

  logic [11:0] exp_dac;
  logic        exp_bit;

  assign adc_in = loopback ? dac_out : adc_force;

  bpsk_modem #(
    .ADC_BITS(12),
    .SYM_LEN (16),
    .RX_DELAY(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .adc_in        (adc_in),
    .bit_data_in   (bit_data_in),
    .bit_data_in_en(bit_data_in_en),
    .bit_data_out  (bit_data_out),
    .dac_out       (dac_out)
  );

  always #5 clk = ~clk;

  // round(2047*sin(2*pi*k/16))
  function automatic int lut_ref(input int k);
    case (k % 16)
      0:  return 0;
      1:  return 783;
      2:  return 1447;
      3:  return 1891;
      4:  return 2047;
      5:  return 1891;
      6:  return 1447;
      7:  return 783;
      8:  return 0;
      9:  return -783;
      10: return -1447;
      11: return -1891;
      12: return -2047;
      13: return -1891;
      14: return -1447;
      default: return -783;
    endcase
  endfunction

  // Bit seen at edge m in the toggle test: starts at 1 and flips every 20 clocks
  function automatic logic toggle_stim(input int m);
    return ((m / 20) % 2) == 0;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    n++;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b0;
    n   = 0;
  endtask

  task automatic test_reset();
    loopback       = 1'b1;
    bit_data_in    = 1'b1;
    bit_data_in_en = 1'b1;
    do_reset(3);
    checks++;
    if (dac_out !== 12'd2048) begin
      errors++;
      $display("FAIL reset_dac: got %0d expected 2048", dac_out);
    end
    checks++;
    if (bit_data_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_bit: got %b expected 0", bit_data_out);
    end
    // First symbol always carries tx_bit=0, so the carrier is inverted
    for (int i = 0; i < 16; i++) begin
      step();
      exp_dac = 12'(2048 - lut_ref(n - 1));
      checks++;
      if (dac_out !== exp_dac) begin
        errors++;
        $display("FAIL reset_first_symbol_dac n=%0d: got %0d expected %0d", n, dac_out, exp_dac);
      end
      checks++;
      if (bit_data_out !== 1'b0) begin
        errors++;
        $display("FAIL reset_first_symbol_bit n=%0d: got %b expected 0", n, bit_data_out);
      end
    end
  endtask

  task automatic test_const_one();
    loopback       = 1'b1;
    bit_data_in    = 1'b1;
    bit_data_in_en = 1'b1;
    do_reset(2);
    while (n < 50) begin
      step();
      if (n >= 17 && n <= 32) begin
        exp_dac = 12'(2048 + lut_ref(n - 1));
        checks++;
        if (dac_out !== exp_dac) begin
          errors++;
          $display("FAIL const_one_dac n=%0d: got %0d expected %0d", n, dac_out, exp_dac);
        end
      end
      if (n >= 18) begin
        exp_bit = (n >= 34);
        checks++;
        if (bit_data_out !== exp_bit) begin
          errors++;
          $display("FAIL const_one_bit n=%0d: got %b expected %b", n, bit_data_out, exp_bit);
        end
      end
    end
  endtask

  // Continues from test_const_one with tx_bit=1 already latched
  task automatic test_en_hold();
    bit_data_in_en = 1'b0;
    while (n < 100) begin
      bit_data_in = ((n % 16) == 7) ? 1'b1 : 1'b0;
      step();
      exp_dac = 12'(2048 + lut_ref(n - 1));
      checks++;
      if (dac_out !== exp_dac) begin
        errors++;
        $display("FAIL en_hold_dac n=%0d: got %0d expected %0d", n, dac_out, exp_dac);
      end
      checks++;
      if (bit_data_out !== 1'b1) begin
        errors++;
        $display("FAIL en_hold_bit n=%0d: got %b expected 1", n, bit_data_out);
      end
    end
  endtask

  // Reset mid-symbol while a positive correlation sum is building
  task automatic test_reset_mid();
    bit_data_in_en = 1'b1;
    bit_data_in    = 1'b1;
    while (n < 106) step();
    do_reset(1);
    checks++;
    if (dac_out !== 12'd2048) begin
      errors++;
      $display("FAIL reset_mid_dac: got %0d expected 2048", dac_out);
    end
    checks++;
    if (bit_data_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_bit: got %b expected 0", bit_data_out);
    end
    while (n < 34) begin
      step();
      if (n <= 3) begin
        exp_dac = 12'(2048 - lut_ref(n - 1));
        checks++;
        if (dac_out !== exp_dac) begin
          errors++;
          $display("FAIL reset_mid_phase n=%0d: got %0d expected %0d", n, dac_out, exp_dac);
        end
      end
      exp_bit = (n >= 34);
      checks++;
      if (bit_data_out !== exp_bit) begin
        errors++;
        $display("FAIL reset_mid_decode n=%0d: got %b expected %b", n, bit_data_out, exp_bit);
      end
    end
  endtask

  task automatic test_toggle();
    loopback       = 1'b1;
    bit_data_in_en = 1'b1;
    bit_data_in    = toggle_stim(1);
    do_reset(2);
    while (n < 240) begin
      bit_data_in = toggle_stim(n + 1);
      step();
      // Symbol w carries the bit seen at edge 16w and decodes over edges 16w+18 .. 16w+33
      exp_bit = (n < 34) ? 1'b0 : toggle_stim(16 * ((n - 18) / 16));
      checks++;
      if (bit_data_out !== exp_bit) begin
        errors++;
        $display("FAIL toggle_bit n=%0d: got %b expected %b", n, bit_data_out, exp_bit);
      end
    end
  endtask

  task automatic test_no_signal();
    loopback       = 1'b0;
    adc_force      = 12'd2048;
    bit_data_in    = 1'b1;
    bit_data_in_en = 1'b1;
    do_reset(2);
    while (n < 160) begin
      // A DC offset still correlates to exactly zero over a full symbol
      if (n == 80) adc_force = 12'd3000;
      step();
      checks++;
      if (bit_data_out !== 1'b0) begin
        errors++;
        $display("FAIL no_signal_bit n=%0d adc=%0d: got %b expected 0", n, adc_force,
                 bit_data_out);
      end
    end
  endtask

  initial begin
    loopback       = 1'b1;
    adc_force      = 12'd2048;
    bit_data_in    = 1'b0;
    bit_data_in_en = 1'b1;
    test_reset();
    test_const_one();
    test_en_hold();
    test_reset_mid();
    test_toggle();
    test_no_signal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
